iommu_reg_bus_resp: RTL and testbench

- SW-side bus responder for the IOMMU register file.
- Accepts single-beat register read/write requests over a valid/ready bus and decodes the address to a register index.
- Drives one-cycle per-register write-enable and read-pulse strobes plus write data and byte enables; these are the we/wd inputs of the per-field write arbiters. A read pulse doubles as the "we" for read-to-clear (RC) fields.
- Captures the addressed register's read data and returns it, with an error flag, over a valid/ready response channel.

---
 rtl/iommu_reg_bus_pkg.sv | 33 +++
 rtl/iommu_reg_addr_decode.sv | 36 +++
 rtl/iommu_reg_bus_resp.sv | 132 +++++++++++++
 tb/tb_iommu_reg_bus_resp.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iommu_reg_bus_pkg.sv
// Shared types and helpers for the IOMMU register bus responder.
// The request/response structs are sized for the widest supported bus;
// users zero-extend into them and slice back out at their own widths.
package iommu_reg_bus_pkg;

    localparam int MAX_ADDR_WIDTH = 32;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Number of byte-offset address bits inside one register word.
    function automatic int word_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [MAX_DATA_WIDTH-1:0] wdata;
        logic [MAX_BE_WIDTH-1:0]   be;
    } bus_req_t;

    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      error;
    } bus_rsp_t;

endpackage

// File: rtl/iommu_reg_addr_decode.sv
// Combinational address decoder for a contiguous window of word-sized
// registers starting at address 0. Flags misaligned, out-of-window and
// writes to read-only registers; the one-hot output is zero on any error.
module iommu_reg_addr_decode
    import iommu_reg_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_write,
    input  logic [NUM_REGS-1:0]   i_ro_regs,
    output logic [IDX_W-1:0]      o_index,
    output logic [NUM_REGS-1:0]   o_onehot,
    output logic                  o_error
);

    localparam int OFF_W  = word_off_bits(DATA_WIDTH);
    localparam int WORD_W = ADDR_WIDTH - OFF_W;

    logic [WORD_W-1:0] w_word;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_ro_hit;

    assign w_word         = i_addr[ADDR_WIDTH-1:OFF_W];
    assign w_misaligned   = |i_addr[OFF_W-1:0];
    assign w_out_of_range = (w_word >= WORD_W'(NUM_REGS));
    assign o_index        = w_word[IDX_W-1:0];
    assign w_ro_hit       = i_write && !w_out_of_range && i_ro_regs[o_index];
    assign o_error        = w_misaligned | w_out_of_range | w_ro_hit;
    assign o_onehot       = o_error ? '0 : (NUM_REGS'(1) << o_index);

endmodule

// File: rtl/iommu_reg_bus_resp.sv
// SW-side bus responder for the IOMMU register file. One request is taken
// in IDLE, decoded and strobed into the field arbiters in ACCESS, and the
// result is held in RESP until the response channel accepts it.
module iommu_reg_bus_resp
    import iommu_reg_bus_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 12,
    parameter int                   DATA_WIDTH = 64,
    parameter int                   NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_REGS    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    input  logic                           req_write_i,
    input  logic [DATA_WIDTH-1:0]          req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        req_be_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                           rsp_error_o,
    output logic [NUM_REGS-1:0]            reg_we_o,
    output logic [NUM_REGS-1:0]            reg_re_o,
    output logic [DATA_WIDTH-1:0]          reg_wd_o,
    output logic [DATA_WIDTH/8-1:0]        reg_be_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e   r_state;
    logic     r_req_ready;
    logic     r_rsp_valid;
    bus_req_t r_req;
    bus_rsp_t r_rsp;

    logic [IDX_W-1:0]      w_index;
    logic [NUM_REGS-1:0]   w_onehot;
    logic                  w_dec_error;
    logic [DATA_WIDTH-1:0] w_rdata_sel;
    logic                  w_access;
    logic                  w_wr_strobe;
    logic                  w_rd_strobe;

    // The latched address is zero-extended, so widening it cannot alias into the window.
    iommu_reg_addr_decode #(
        .ADDR_WIDTH (MAX_ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .i_addr    (r_req.addr),
        .i_write   (r_req.write),
        .i_ro_regs (RO_REGS),
        .o_index   (w_index),
        .o_onehot  (w_onehot),
        .o_error   (w_dec_error)
    );

    assign w_access    = (r_state == ACCESS);
    assign w_wr_strobe = w_access && r_req.write && (|r_req.be[BE_W-1:0]);
    assign w_rd_strobe = w_access && !r_req.write;

    assign reg_we_o    = w_wr_strobe ? w_onehot : '0;
    assign reg_re_o    = w_rd_strobe ? w_onehot : '0;
    assign reg_wd_o    = r_req.wdata[DATA_WIDTH-1:0];
    assign reg_be_o    = r_req.be[BE_W-1:0];

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp.rdata[DATA_WIDTH-1:0];
    assign rsp_error_o = r_rsp.error;

    // Select the addressed register's contents, zero when the decode flags an error.
    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!w_dec_error && (w_index == IDX_W'(i))) begin
                w_rdata_sel = reg_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction FSM: read data is captured at the end of ACCESS so RC fields return their pre-clear value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req       <= '0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_req_ready && req_valid_i) begin
                        r_req.addr  <= MAX_ADDR_WIDTH'(req_addr_i);
                        r_req.write <= req_write_i;
                        r_req.wdata <= MAX_DATA_WIDTH'(req_wdata_i);
                        r_req.be    <= MAX_BE_WIDTH'(req_be_i);
                        r_req_ready <= 1'b0;
                        r_state     <= ACCESS;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_rsp.error <= w_dec_error;
                    r_rsp.rdata <= r_req.write ? '0 : MAX_DATA_WIDTH'(w_rdata_sel);
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp       <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iommu_reg_bus_resp.sv
// Testbench for iommu_reg_bus_resp with a small register-file environment
// (register 4 is read-to-clear, register 0 is read-only) and a shadow model
// that predicts strobes and responses from the address map rules.
module tb_iommu_reg_bus_resp;

    localparam int          NREGS  = 16;
    localparam logic [15:0] RO     = 16'h0001;
    localparam int          RC_IDX = 4;

    typedef struct packed {
        logic        timeout;
        logic [15:0] we1;
        logic [15:0] re1;
        logic [63:0] wd1;
        logic [7:0]  be1;
        logic        ready1;
        logic        v2;
        logic [63:0] rdata2;
        logic        err2;
        logic [15:0] we2;
        logic [15:0] re2;
        logic        stable;
        logic        v_after;
        logic [63:0] rdata_after;
        logic        err_after;
        logic        ready_after;
    } obs_t;

    logic               clk_i;
    logic               rst_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [11:0]        req_addr_i;
    logic               req_write_i;
    logic [63:0]        req_wdata_i;
    logic [7:0]         req_be_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [63:0]        rsp_rdata_o;
    logic               rsp_error_o;
    logic [15:0]        reg_we_o;
    logic [15:0]        reg_re_o;
    logic [63:0]        reg_wd_o;
    logic [7:0]         reg_be_o;
    logic [NREGS*64-1:0] reg_rdata_i;

    logic [63:0] env_regs [NREGS];
    logic [63:0] shadow   [NREGS];
    logic        bd_en;
    int          bd_idx;
    logic [63:0] bd_val;

    int total;
    int bad;

    iommu_reg_bus_resp #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (64),
        .NUM_REGS   (NREGS),
        .RO_REGS    (RO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_wd_o    (reg_wd_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i)
    );

    // Free-running clock, period 10.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Register-file environment: byte-masked writes, RC clear of register 4, backdoor preload.
    always @(posedge clk_i) begin
        if (bd_en) env_regs[bd_idx] <= bd_val;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_we_o[i]) begin
                for (int k = 0; k < 8; k++) begin
                    if (reg_be_o[k]) env_regs[i][k*8 +: 8] <= reg_wd_o[k*8 +: 8];
                end
            end
            if (reg_re_o[i] && i == RC_IDX) env_regs[i] <= '0;
        end
    end

    // Flatten the environment registers onto the DUT read-data bus.
    always_comb begin
        reg_rdata_i = '0;
        for (int i = 0; i < NREGS; i++) reg_rdata_i[i*64 +: 64] = env_regs[i];
    end

    // Global time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: address-map rules applied to the shadow register file.
    task automatic model(input logic [11:0] a, input logic w, input logic [63:0] d, input logic [7:0] b,
                         output logic [15:0] ewe, output logic [15:0] ere, output logic [63:0] erd,
                         output logic eerr);
        int idx;
        idx  = int'(a) / 8;
        eerr = (a % 8 != 0) || (idx >= NREGS) || (w && (idx < NREGS) && RO[idx]);
        ewe  = '0;
        ere  = '0;
        erd  = '0;
        if (!eerr) begin
            if (w) begin
                if (b != 8'h00) begin
                    ewe[idx] = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        if (b[k]) shadow[idx][k*8 +: 8] = d[k*8 +: 8];
                    end
                end
            end else begin
                ere[idx] = 1'b1;
                erd      = shadow[idx];
                if (idx == RC_IDX) shadow[idx] = '0;
            end
        end
    endtask

    // Backdoor load of one environment register and its shadow copy.
    task automatic backdoor(input int idx, input logic [63:0] v);
        @(negedge clk_i);
        bd_en  = 1'b1;
        bd_idx = idx;
        bd_val = v;
        @(negedge clk_i);
        bd_en = 1'b0;
        shadow[idx] = v;
    endtask

    // Drive one transaction and record what the DUT shows in each phase.
    task automatic drive_txn(input logic [11:0] a, input logic w, input logic [63:0] d, input logic [7:0] b,
                             input int stall, input bit poke, output obs_t o);
        int cnt;
        o = '0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = d;
        req_be_i    = b;
        cnt = 0;
        while (req_ready_o !== 1'b1 && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
        end
        if (req_ready_o !== 1'b1) begin
            o.timeout   = 1'b1;
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = poke;
        if (poke) begin
            req_addr_i  = a ^ 12'h008;
            req_write_i = 1'b1;
            req_wdata_i = ~d;
            req_be_i    = 8'hFF;
        end
        @(negedge clk_i);
        o.we1    = reg_we_o;
        o.re1    = reg_re_o;
        o.wd1    = reg_wd_o;
        o.be1    = reg_be_o;
        o.ready1 = req_ready_o;
        @(negedge clk_i);
        o.v2     = rsp_valid_o;
        o.rdata2 = rsp_rdata_o;
        o.err2   = rsp_error_o;
        o.we2    = reg_we_o;
        o.re2    = reg_re_o;
        o.stable = (req_ready_o === 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== o.rdata2 || rsp_error_o !== o.err2 ||
                req_ready_o !== 1'b0 || reg_we_o !== 16'h0 || reg_re_o !== 16'h0 || reg_wd_o !== d)
                o.stable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i   = 1'b0;
        req_valid_i   = 1'b0;
        o.v_after     = rsp_valid_o;
        o.rdata_after = rsp_rdata_o;
        o.err_after   = rsp_error_o;
        o.ready_after = req_ready_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        total++;
        if ({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, reg_we_o, reg_re_o, reg_wd_o, reg_be_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got ready=%b v=%b rd=%h err=%b we=%h re=%h wd=%h be=%h want all 0",
                     req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, reg_we_o, reg_re_o, reg_wd_o, reg_be_o);
        end
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++;
        if (req_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready_before_edge got=%b want=0", req_ready_o);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready_after_edge got=%b want=1", req_ready_o);
        end
        for (int i = 0; i < NREGS; i++) backdoor(i, {$urandom, $urandom});
    endtask

    task automatic test_write_basic();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd;
        logic eerr;
        model(12'h018, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, ewe, ere, erd, eerr);
        drive_txn(12'h018, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1'b0, o);
        total++;
        if (o.we1 !== 16'h0008 || o.re1 !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL write_strobe got we=%h re=%h want we=0008 re=0000", o.we1, o.re1);
        end
        total++;
        if (o.wd1 !== 64'hDEAD_BEEF_0000_0001 || o.be1 !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL write_wd_be got wd=%h be=%h want wd=deadbeef00000001 be=ff", o.wd1, o.be1);
        end
        total++;
        if ({o.v2, o.err2, o.rdata2, o.we2} !== {1'b1, 1'b0, 64'h0, 16'h0}) begin
            bad++;
            $display("[TB] FAIL write_rsp got v=%b err=%b rd=%h we=%h want v=1 err=0 rd=0 we=0",
                     o.v2, o.err2, o.rdata2, o.we2);
        end
        total++;
        if ({o.v_after, o.rdata_after, o.err_after, o.ready_after} !== {1'b0, 64'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL write_after got v=%b rd=%h err=%b ready=%b want v=0 rd=0 err=0 ready=1",
                     o.v_after, o.rdata_after, o.err_after, o.ready_after);
        end
    endtask

    task automatic test_read_rc();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd;
        logic eerr;
        backdoor(RC_IDX, 64'h5A);
        model(12'h020, 1'b0, 64'h0, 8'h00, ewe, ere, erd, eerr);
        drive_txn(12'h020, 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
        total++;
        if (o.re1 !== 16'h0010 || o.we1 !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL rc_strobe got re=%h we=%h want re=0010 we=0000", o.re1, o.we1);
        end
        total++;
        if (o.rdata2 !== 64'h5A || o.err2 !== 1'b0 || o.re2 !== 16'h0) begin
            bad++;
            $display("[TB] FAIL rc_rdata got rd=%h err=%b re=%h want rd=5a err=0 re=0", o.rdata2, o.err2, o.re2);
        end
        model(12'h020, 1'b0, 64'h0, 8'h00, ewe, ere, erd, eerr);
        drive_txn(12'h020, 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
        total++;
        if (o.rdata2 !== erd) begin
            bad++;
            $display("[TB] FAIL rc_cleared got rd=%h want rd=%h", o.rdata2, erd);
        end
    endtask

    task automatic test_errors();
        obs_t o;
        logic [11:0] addrs [2];
        addrs[0] = 12'h01C;
        addrs[1] = 12'h080;
        for (int i = 0; i < 2; i++) begin
            drive_txn(addrs[i], 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
            total++;
            if (o.we1 !== 16'h0 || o.re1 !== 16'h0) begin
                bad++;
                $display("[TB] FAIL err_strobe addr=%h got we=%h re=%h want 0", addrs[i], o.we1, o.re1);
            end
            total++;
            if (o.v2 !== 1'b1 || o.err2 !== 1'b1 || o.rdata2 !== 64'h0) begin
                bad++;
                $display("[TB] FAIL err_rsp addr=%h got v=%b err=%b rd=%h want v=1 err=1 rd=0",
                         addrs[i], o.v2, o.err2, o.rdata2);
            end
        end
    endtask

    task automatic test_read_only();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd;
        logic eerr;
        model(12'h000, 1'b1, 64'h1234, 8'hFF, ewe, ere, erd, eerr);
        drive_txn(12'h000, 1'b1, 64'h1234, 8'hFF, 0, 1'b0, o);
        total++;
        if (o.we1 !== 16'h0 || o.err2 !== 1'b1 || o.rdata2 !== 64'h0) begin
            bad++;
            $display("[TB] FAIL ro_write got we=%h err=%b rd=%h want we=0 err=1 rd=0", o.we1, o.err2, o.rdata2);
        end
        model(12'h000, 1'b0, 64'h0, 8'h00, ewe, ere, erd, eerr);
        drive_txn(12'h000, 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
        total++;
        if (o.re1 !== 16'h0001 || o.err2 !== 1'b0 || o.rdata2 !== erd) begin
            bad++;
            $display("[TB] FAIL ro_read got re=%h err=%b rd=%h want re=0001 err=0 rd=%h", o.re1, o.err2, o.rdata2, erd);
        end
    endtask

    task automatic test_back_to_back_stall();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd;
        logic eerr;
        model(12'h038, 1'b1, 64'hCAFE_F00D_1234_5678, 8'h0F, ewe, ere, erd, eerr);
        drive_txn(12'h038, 1'b1, 64'hCAFE_F00D_1234_5678, 8'h0F, 5, 1'b1, o);
        total++;
        if (o.stable !== 1'b1 || o.ready1 !== 1'b0 || o.v2 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_hold got stable=%b ready1=%b v=%b want stable=1 ready1=0 v=1",
                     o.stable, o.ready1, o.v2);
        end
        total++;
        if (o.v_after !== 1'b0 || o.ready_after !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_release got v=%b ready=%b want v=0 ready=1", o.v_after, o.ready_after);
        end
        for (int r = 6; r <= 8; r++) begin
            model(12'(r * 8), 1'b0, 64'h0, 8'h00, ewe, ere, erd, eerr);
            drive_txn(12'(r * 8), 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
            total++;
            if (o.rdata2 !== erd || o.err2 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_readback reg=%0d got rd=%h err=%b want rd=%h err=0", r, o.rdata2, o.err2, erd);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd;
        logic eerr;
        bit quiet;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 12'h028;
        req_write_i = 1'b1;
        req_wdata_i = 64'hFFFF_0000_FFFF_0000;
        req_be_i    = 8'hFF;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (reg_we_o !== 16'h0020) begin
            bad++;
            $display("[TB] FAIL midrst_strobe got we=%h want we=0020", reg_we_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (reg_we_o !== 16'h0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || reg_wd_o !== 64'h0) begin
            bad++;
            $display("[TB] FAIL midrst_async got we=%h v=%b ready=%b wd=%h want all 0",
                     reg_we_o, rsp_valid_o, req_ready_o, reg_wd_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_ready got=%b want=1", req_ready_o);
        end
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0 || reg_we_o !== 16'h0 || reg_re_o !== 16'h0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_quiet got activity after reset want none");
        end
        model(12'h028, 1'b0, 64'h0, 8'h00, ewe, ere, erd, eerr);
        drive_txn(12'h028, 1'b0, 64'h0, 8'h00, 0, 1'b0, o);
        total++;
        if (o.rdata2 !== erd) begin
            bad++;
            $display("[TB] FAIL midrst_dropped got rd=%h want rd=%h", o.rdata2, erd);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [15:0] ewe, ere;
        logic [63:0] erd, d;
        logic [11:0] a;
        logic [7:0] b;
        logic w, eerr;
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 12'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
            else if (kind == 1) a = 12'($urandom_range(16, 511) * 8);
            else                a = 12'($urandom_range(0, 15) * 8);
            w = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            d = {$urandom, $urandom};
            model(a, w, d, b, ewe, ere, erd, eerr);
            drive_txn(a, w, d, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), o);
            total++;
            if (o.timeout !== 1'b0 || o.we1 !== ewe || o.re1 !== ere) begin
                bad++;
                $display("[TB] FAIL rand_strobe n=%0d addr=%h w=%b got to=%b we=%h re=%h want we=%h re=%h",
                         n, a, w, o.timeout, o.we1, o.re1, ewe, ere);
            end
            total++;
            if (o.wd1 !== d || o.be1 !== b) begin
                bad++;
                $display("[TB] FAIL rand_wd n=%0d got wd=%h be=%h want wd=%h be=%h", n, o.wd1, o.be1, d, b);
            end
            total++;
            if (o.v2 !== 1'b1 || o.rdata2 !== erd || o.err2 !== eerr || o.we2 !== 16'h0 || o.re2 !== 16'h0) begin
                bad++;
                $display("[TB] FAIL rand_rsp n=%0d addr=%h got v=%b rd=%h err=%b want v=1 rd=%h err=%b",
                         n, a, o.v2, o.rdata2, o.err2, erd, eerr);
            end
            total++;
            if (o.stable !== 1'b1 || o.v_after !== 1'b0 || o.rdata_after !== 64'h0 || o.err_after !== 1'b0 ||
                o.ready_after !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rand_hold n=%0d got stable=%b v=%b rd=%h err=%b ready=%b want 1 0 0 0 1",
                         n, o.stable, o.v_after, o.rdata_after, o.err_after, o.ready_after);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        bd_en       = 1'b0;
        bd_idx      = 0;
        bd_val      = '0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < NREGS; i++) shadow[i] = '0;
        test_reset();
        test_write_basic();
        test_read_rc();
        test_errors();
        test_read_only();
        test_back_to_back_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
